// File: rtl/cordic_linear_engine.sv
// Linear-mode CORDIC vectoring divider: z = y_in / x_in by shift-add iterations.
// Accepts a one-cycle start in IDLE, runs ITER iterations, returns a one-cycle done.
module cordic_linear_engine #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30,
  parameter int ITER  = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_out
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  // Two guard bits let the residual swing to +/-4 without wrapping.
  localparam int YW = WIDTH + 2;
  localparam logic [CW-1:0]    LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [WIDTH-1:0]     x_r, x_s;
  logic signed [YW-1:0] y_r, y_s;
  logic [WIDTH-1:0]     z_r, z_s;
  logic [WIDTH-1:0]     z_out_r, z_out_s;
  logic                 busy_r, done_r;
  logic signed [YW-1:0] x_sh_s;
  logic [WIDTH-1:0]     step_s, z_nxt_s;
  logic [31:0]          shamt_s;

  // Shifted divisor and exact z step (2^(FRAC-i)) for the current iteration
  always_comb begin
    shamt_s = 32'(FRAC) - 32'(cnt_r);
    x_sh_s  = $signed({{2{x_r[WIDTH-1]}}, x_r}) >>> cnt_r;
    step_s  = ONE << shamt_s;
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    x_s     = x_r;
    y_s     = y_r;
    z_s     = z_r;
    z_out_s = z_out_r;
    z_nxt_s = z_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
          cnt_s   = {CW{1'b0}};
          x_s     = x_in;
          y_s     = $signed({{2{y_in[WIDTH-1]}}, y_in});
          z_s     = {WIDTH{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // Non-negative residual: remove divisor, credit quotient
        if (y_r[YW-1] == 1'b0) begin
          y_s     = y_r - x_sh_s;
          z_nxt_s = z_r + step_s;
        end else begin
          y_s     = y_r + x_sh_s;
          z_nxt_s = z_r - step_s;
        end
        z_s = z_nxt_s;
        if (cnt_r == LAST) begin
          state_s = DONE;
          z_out_s = z_nxt_s;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {YW{1'b0}};
      z_r     <= {WIDTH{1'b0}};
      z_out_r <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      x_r     <= x_s;
      y_r     <= y_s;
      z_r     <= z_s;
      z_out_r <= z_out_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign z_out = z_out_r;

endmodule

// File: tb/tb_cordic_linear_engine.sv
// Scoreboard bench for cordic_linear_engine: real-arithmetic quotient model,
// directed corner cases plus randomized operands, handshake and reset checks.
module tb_cordic_linear_engine;

  localparam int WIDTH    = 32;
  localparam int FRAC     = 30;
  localparam int ITER     = 31;
  localparam int TOL_PLAN = 4;
  // General accuracy bound: 2^-(ITER-1) (1 LSB) plus ITER LSB of truncation.
  localparam int TOL_RAND = ITER + 1;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] x_in  = '0;
  logic [WIDTH-1:0] y_in  = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [WIDTH-1:0] z;
    int               tol;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  cordic_linear_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .busy  (busy),
    .done  (done),
    .z_out (z_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Quotient y/x in QFRAC, rounded, clamped to the saturation value.
  function automatic logic [WIDTH-1:0] model_div(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    real    r;
    real    lim;
    longint q;
    lim = 2.0 ** (WIDTH - 1) - 1.0;
    r   = $itor($signed(y)) / $itor($signed(x)) * (2.0 ** FRAC);
    if (r > lim) r = lim;
    if (r < -lim) r = -lim;
    q = longint'(r);
    return q[WIDTH-1:0];
  endfunction

  task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp, input int tol);
    longint d;
    n_vec++;
    d = longint'($signed(got)) - longint'($signed(exp));
    if (d < 0) d = -d;
    if ((^got === 1'bx) || (d > tol)) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h +/-%0d", name, got, exp, tol);
    end
  endtask

  // Monitor: every done pulse pops and checks one scoreboard entry
  always @(negedge clk) begin
    if (rst && (done === 1'b1)) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: done with no pending op, z_out=0x%h", z_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk_tol("z_out", z_out, mon_e.z, mon_e.tol);
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int tol, input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    x_in  = x;
    y_in  = y;
    if (expect_done) begin
      e.z   = model_div(x, y);
      e.tol = tol;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = $urandom;
    y_in  = $urandom;
  endtask

  // Called at accept edge + #1; checks latency, busy span and done width.
  task automatic wait_done(input string name);
    int k;
    int busy_n;
    bit seen;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k <= 200) begin
      @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1'b1;
      else k++;
    end
    chk_eq({name, "_done_seen"}, seen, 1);
    if (seen) begin
      chk_eq({name, "_latency"}, k, ITER);
      chk_eq({name, "_busy_cycles"}, busy_n, ITER + 1);
      @(negedge clk);
      chk_eq({name, "_done_width"}, done, 0);
      chk_eq({name, "_busy_idle"}, busy, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int t[3];
    logic [WIDTH-1:0] rx, ry;

    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_z_out", z_out, 0);
    @(negedge clk) rst = 1'b1;

    issue(32'h4000_0000, 32'h4000_0000, TOL_PLAN, 1'b1); wait_done("recip");
    issue(32'h6000_0000, 32'h4000_0000, TOL_PLAN, 1'b1); wait_done("frac_1p5");
    issue(32'h7FFF_FFFF, 32'h4000_0000, TOL_PLAN, 1'b1); wait_done("frac_max_x");
    issue(32'h4000_0000, 32'hE000_0000, TOL_PLAN, 1'b1); wait_done("neg_div");
    issue(32'h4000_0000, 32'h7FFF_FFFF, 0, 1'b1);        wait_done("sat_pos");
    issue(32'h4000_0000, 32'h8000_0001, 0, 1'b1);        wait_done("sat_neg");

    // Abort at iteration 10: outputs clear immediately, no done afterwards
    issue(32'h6000_0000, 32'hC000_0000, TOL_PLAN, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_done", done, 0);
    chk_eq("abort_z_out", z_out, 0);
    @(negedge clk) rst = 1'b1;
    repeat (40) @(negedge clk);
    chk_eq("abort_idle_busy", busy, 0);
    issue(32'h5000_0000, 32'h2000_0000, TOL_PLAN, 1'b1); wait_done("after_abort");

    // Stray start pulses in RUN and in the DONE cycle are ignored
    issue(32'h5000_0000, 32'h3000_0000, TOL_PLAN, 1'b1);
    nd = 0;
    for (int k = 1; k <= ITER + 40; k++) begin
      @(posedge clk); #1;
      start = (k == 5) || (k == ITER);
      x_in  = 32'h4000_0000;
      y_in  = $urandom;
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    start = 1'b0;
    chk_eq("ignore_done_count", nd, 1);
    chk_tol("ignore_z_held", z_out, model_div(32'h5000_0000, 32'h3000_0000), TOL_PLAN);
    chk_eq("ignore_busy", busy, 0);

    // start held high: back-to-back ops every ITER+2 cycles
    rx = 32'h4800_0000; ry = 32'hD000_0000;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.z = model_div(rx, ry);
      e.tol = TOL_PLAN;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; x_in = rx; y_in = ry;
    nd = 0;
    for (int k = 0; k < 200 && nd < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    chk_eq("held_done_count", nd, 3);
    if (nd == 3) begin
      chk_eq("held_period_1", t[1] - t[0], ITER + 2);
      chk_eq("held_period_2", t[2] - t[1], ITER + 2);
    end
    repeat (40) @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      rx = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
      ry = $urandom;
      if (ry == 32'h8000_0000) ry = 32'h8000_0001;
      issue(rx, ry, TOL_RAND, 1'b1);
      wait_done("rand");
    end

    repeat (5) @(negedge clk);
    chk_eq("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
